// File: rtl/sram_march_bist_if.sv
// Port-0 bus between the March BIST engine (master) and a single-port SRAM macro (slave).
interface sram_march_bist_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_WMASKS = 4
);
    logic                  csb0;
    logic                  web0;
    logic [NUM_WMASKS-1:0] wmask0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic [DATA_WIDTH-1:0] dout0;

    modport master (output csb0, web0, wmask0, addr0, din0, input dout0);
    modport slave  (input csb0, web0, wmask0, addr0, din0, output dout0);
endinterface

// File: rtl/sram_march_bist.sv
// March C- style BIST (w0 up, r0/w1 up, r1 down) for a single-port SRAM with abort and first-fail capture.
// Define ERR_COUNT_EN to add a saturating 16-bit mismatch counter output (err_count).
module sram_march_bist #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    NUM_WMASKS = 4,
    parameter logic [DATA_WIDTH-1:0] PATTERN    = 32'h5555_5555
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] fail_addr,
`ifdef ERR_COUNT_EN
    output logic [15:0]           err_count,
`endif
    sram_march_bist_if.master     bus
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

    typedef enum logic [2:0] {IDLE, W0, R0W1, R1, FLUSH, DONE} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  phase_q, phase_d;      // R0W1: 0 = read cycle, 1 = compare + write cycle
    logic                  rd_pend_q, rd_pend_d;  // an R1 read is in flight, compare this cycle
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic                  pass_q, pass_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  csb0_q, csb0_d;
    logic                  web0_q, web0_d;
    logic [DATA_WIDTH-1:0] din0_q, din0_d;
`ifdef ERR_COUNT_EN
    logic [15:0]           cnt_q, cnt_d;
`endif

    logic                  cmp_en;
    logic [DATA_WIDTH-1:0] cmp_exp;
    logic [ADDR_WIDTH-1:0] cmp_addr;
    logic                  mismatch;

    always_comb begin
        // NOTE: every value written below gets a default first, so no path through the case infers a latch.
        state_d     = state_q;
        addr_d      = addr_q;
        phase_d     = phase_q;
        rd_pend_d   = 1'b0;
        rd_addr_d   = rd_addr_q;
        err_d       = err_q;
        fail_addr_d = fail_addr_q;
        pass_d      = pass_q;
`ifdef ERR_COUNT_EN
        cnt_d       = cnt_q;
`endif

        // Read data returns one cycle after the read: R0W1 checks in its write cycle, R1 one cycle late.
        cmp_en   = (state_q == R0W1) && phase_q;
        cmp_exp  = PATTERN;
        cmp_addr = addr_q;
        if (rd_pend_q) begin
            cmp_en   = 1'b1;
            cmp_exp  = ~PATTERN;
            cmp_addr = rd_addr_q;
        end
        mismatch = cmp_en && (bus.dout0 != cmp_exp);

        if (mismatch) begin
            if (!err_q) begin
                err_d       = 1'b1;
                fail_addr_d = cmp_addr;
            end
`ifdef ERR_COUNT_EN
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
`endif
        end

        unique case (state_q)
            IDLE, DONE: begin
                if (start && !abort) begin
                    state_d     = W0;
                    addr_d      = '0;
                    phase_d     = 1'b0;
                    err_d       = 1'b0;
                    fail_addr_d = '0;
                    pass_d      = 1'b0;
`ifdef ERR_COUNT_EN
                    cnt_d       = '0;
`endif
                end
            end
            W0: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = R0W1;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            R0W1: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (addr_q == ADDR_LAST) begin
                        state_d = R1;
                        addr_d  = ADDR_LAST;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            R1: begin
                rd_pend_d = 1'b1;
                rd_addr_d = addr_q;
                if (addr_q == '0) state_d = FLUSH;
                else              addr_d  = addr_q - 1'b1;
            end
            FLUSH: begin
                state_d = DONE;
                pass_d  = !(err_q || mismatch);
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over start and every transition computed above.
        if (abort && busy_q) begin
            state_d   = IDLE;
            addr_d    = '0;
            phase_d   = 1'b0;
            rd_pend_d = 1'b0;
            pass_d    = 1'b0;
        end

        busy_d = state_d inside {W0, R0W1, R1, FLUSH};
        done_d = (state_d == DONE);
        csb0_d = !(state_d inside {W0, R0W1, R1});
        web0_d = !((state_d == W0) || ((state_d == R0W1) && phase_d));
        if (state_d == W0)  din0_d = PATTERN;
        else if (!web0_d)   din0_d = ~PATTERN;
        else                din0_d = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge _d values together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            phase_q     <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_addr_q   <= '0;
            err_q       <= 1'b0;
            fail_addr_q <= '0;
            pass_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            csb0_q      <= 1'b1;
            web0_q      <= 1'b1;
            din0_q      <= '0;
`ifdef ERR_COUNT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            phase_q     <= phase_d;
            rd_pend_q   <= rd_pend_d;
            rd_addr_q   <= rd_addr_d;
            err_q       <= err_d;
            fail_addr_q <= fail_addr_d;
            pass_q      <= pass_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            csb0_q      <= csb0_d;
            web0_q      <= web0_d;
            din0_q      <= din0_d;
`ifdef ERR_COUNT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_addr  = fail_addr_q;
    assign bus.csb0   = csb0_q;
    assign bus.web0   = web0_q;
    assign bus.wmask0 = {NUM_WMASKS{1'b1}};
    assign bus.addr0  = addr_q;
    assign bus.din0   = din0_q;
`ifdef ERR_COUNT_EN
    assign err_count  = cnt_q;
`endif

endmodule

// File: tb/tb_sram_march_bist.sv
// Self-checking bench for sram_march_bist: faulty SRAM model plus an algorithm-level March reference.
module tb_sram_march_bist;

    localparam int          DW    = 32;
    localparam int          AW    = 4;
    localparam int          NW    = 4;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] PAT   = 32'h5555_5555;

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic          busy, done, pass;
    logic [AW-1:0] fail_addr;
`ifdef ERR_COUNT_EN
    logic [15:0]   err_count;
`endif

    sram_march_bist_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NW)) bus ();

    sram_march_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NW), .PATTERN(PAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr),
`ifdef ERR_COUNT_EN
        .err_count (err_count),
`endif
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // SRAM with per-cell stuck-at-1 / stuck-at-0 bit masks applied on read
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] sa1 [DEPTH];
    logic [DW-1:0] sa0 [DEPTH];

    always @(posedge clk) begin
        if (!bus.csb0) begin
            if (!bus.web0) begin
                for (int b = 0; b < NW; b++)
                    if (bus.wmask0[b]) mem[bus.addr0][b*8 +: 8] <= bus.din0[b*8 +: 8];
            end else begin
                bus.dout0 <= (mem[bus.addr0] | sa1[bus.addr0]) & ~sa0[bus.addr0];
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          busy;
        logic          done;
        logic          csb0;
        logic          web0;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        bit            chk_din;
        bit            chk_pass;
        logic          pass;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   cyc_busy = 0;

    function automatic exp_t mk(logic b, logic d, logic cs, logic we, int a,
                                logic [DW-1:0] din, bit cd, bit cp, logic p);
        exp_t e;
        e.busy = b; e.done = d; e.csb0 = cs; e.web0 = we; e.addr = AW'(a);
        e.din = din; e.chk_din = cd; e.chk_pass = cp; e.pass = p;
        return e;
    endfunction

    // Expected per-cycle bus activity of one complete test, starting the cycle after start is accepted
    function automatic int push_test(logic exp_pass);
        int n = 0;
        for (int a = 0; a < DEPTH; a++) begin exp_q.push_back(mk(1, 0, 0, 0, a, PAT, 1, 0, 0)); n++; end
        for (int a = 0; a < DEPTH; a++) begin
            exp_q.push_back(mk(1, 0, 0, 1, a, '0, 0, 0, 0));
            exp_q.push_back(mk(1, 0, 0, 0, a, ~PAT, 1, 0, 0));
            n += 2;
        end
        for (int a = DEPTH - 1; a >= 0; a--) begin exp_q.push_back(mk(1, 0, 0, 1, a, '0, 0, 0, 0)); n++; end
        exp_q.push_back(mk(1, 0, 1, 1, 0, '0, 0, 0, 0)); n++;
        exp_q.push_back(mk(0, 1, 1, 1, 0, '0, 0, 1, exp_pass));
        return n;
    endfunction

    // Algorithm-level reference: run the march over an array and list the mismatches it sees
    task automatic model_run(output logic exp_pass, output logic [AW-1:0] exp_fa, output int exp_cnt);
        logic [DW-1:0] m [DEPTH];
        logic [DW-1:0] r;
        exp_pass = 1'b1; exp_fa = '0; exp_cnt = 0;
        for (int a = 0; a < DEPTH; a++) m[a] = PAT;
        for (int a = 0; a < DEPTH; a++) begin
            r = (m[a] | sa1[a]) & ~sa0[a];
            if (r != PAT) begin
                if (exp_pass) exp_fa = AW'(a);
                exp_pass = 1'b0; exp_cnt++;
            end
            m[a] = ~PAT;
        end
        for (int a = DEPTH - 1; a >= 0; a--) begin
            r = (m[a] | sa1[a]) & ~sa0[a];
            if (r != ~PAT) begin
                if (exp_pass) exp_fa = AW'(a);
                exp_pass = 1'b0; exp_cnt++;
            end
        end
    endtask

    // Single compare process: one expected entry per cycle, sampled on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (busy === 1'b1) cyc_busy++;
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                check("cyc_busy", busy, cur.busy);
                check("cyc_done", done, cur.done);
                check("cyc_csb0", bus.csb0, cur.csb0);
                check("cyc_wmask0", bus.wmask0, {NW{1'b1}});
                if (!cur.csb0) begin
                    check("cyc_web0", bus.web0, cur.web0);
                    check("cyc_addr0", bus.addr0, cur.addr);
                    if (cur.chk_din) check("cyc_din0", bus.din0, cur.din);
                end
                if (cur.chk_pass) check("cyc_pass", pass, cur.pass);
            end
        end
    end

    task automatic clear_faults();
        for (int a = 0; a < DEPTH; a++) begin sa1[a] = '0; sa0[a] = '0; end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin @(posedge clk); #1; n++; end
        if (exp_q.size() > 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic launch(output int base, output logic p, output logic [AW-1:0] fa, output int cnt);
        model_run(p, fa, cnt);
        @(posedge clk); #1 start = 1'b1;
        base = cyc_busy;
        @(posedge clk); #1 start = 1'b0;
        void'(push_test(p));
    endtask

    task automatic run_full(output logic p, output logic [AW-1:0] fa, output int cnt);
        int base;
        launch(base, p, fa, cnt);
        wait_drain(400);
        check("end_done", done, 1'b1);
        check("end_busy", busy, 1'b0);
        check("end_pass", pass, p);
        check("end_fail_addr", fail_addr, fa);
        check("end_busy_cycles", cyc_busy - base, 4 * DEPTH + 1);
`ifdef ERR_COUNT_EN
        check("end_err_count", err_count, cnt);
`endif
    endtask

    task automatic inject_random();
        int k = $urandom_range(1, 3);
        for (int i = 0; i < k; i++) begin
            int a = $urandom_range(0, DEPTH - 1);
            int b = $urandom_range(0, DW - 1);
            if ($urandom_range(0, 1) == 1) sa1[a][b] = 1'b1;
            else                           sa0[a][b] = 1'b1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_pass"}, pass, 1'b0);
        check({tag, "_fail_addr"}, fail_addr, '0);
        check({tag, "_csb0"}, bus.csb0, 1'b1);
        check({tag, "_web0"}, bus.web0, 1'b1);
        check({tag, "_wmask0"}, bus.wmask0, {NW{1'b1}});
        check({tag, "_addr0"}, bus.addr0, '0);
        check({tag, "_din0"}, bus.din0, '0);
    endtask

    initial begin
        logic          p;
        logic [AW-1:0] fa;
        int            cnt;
        int            base;

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        clear_faults();
        #12;
        check_reset_outputs("por");
        #11 rst = 1'b0;

        // Model pins: one full test is 65 busy cycles at ADDR_WIDTH=4
        check("model_busy_len", push_test(1'b1), 65);
        exp_q.delete();

        // Ideal SRAM
        run_full(p, fa, cnt);
        check("ideal_pass", pass, 1'b1);
        check("ideal_fail_addr", fail_addr, 4'h0);

        // Stuck-at-1 on bit 0 of address 3: only the R1 read (AAAA_AAAB) mismatches
        clear_faults(); sa1[3][0] = 1'b1;
        run_full(p, fa, cnt);
        check("sa1_model_fa", fa, 4'h3);
        check("sa1_model_cnt", cnt, 1);
        check("sa1_pass", pass, 1'b0);
        check("sa1_fail_addr", fail_addr, 4'h3);

        // Data stuck at 0 on addresses 5 and 9: first found at 5 in R0W1, four mismatches total
        clear_faults(); sa0[5] = '1; sa0[9] = '1;
        run_full(p, fa, cnt);
        check("sa0_model_fa", fa, 4'h5);
        check("sa0_model_cnt", cnt, 4);
        check("sa0_fail_addr", fail_addr, 4'h5);

        // Abort at W0 address 7, then a clean full test
        clear_faults();
        launch(base, p, fa, cnt);
        repeat (7) begin @(posedge clk); #1; end
        check("abort_at_addr", bus.addr0, 4'h7);
        abort = 1'b1;
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        exp_q.push_back(mk(0, 0, 1, 1, 0, '0, 0, 1, 1'b0));
        @(posedge clk); #1 abort = 1'b0;
        wait_drain(10);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_csb0", bus.csb0, 1'b1);
        repeat (3) @(posedge clk); #1;
        check("abort_stays_idle", busy, 1'b0);
        run_full(p, fa, cnt);
        check("after_abort_pass", pass, 1'b1);

        // start held high: ignored while busy, restarts out of DONE
        model_run(p, fa, cnt);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1;
        void'(push_test(p));
        void'(push_test(p));
        repeat (66) begin @(posedge clk); #1; end
        start = 1'b0;
        wait_drain(400);
        check("held_done", done, 1'b1);
        check("held_pass", pass, 1'b1);

        // Randomized fault patterns against the reference march
        for (int it = 0; it < 4; it++) begin
            clear_faults();
            inject_random();
            run_full(p, fa, cnt);
        end

        // Reset in the middle of R0W1: immediate reset values, no done
        clear_faults();
        launch(base, p, fa, cnt);
        repeat (20) begin @(posedge clk); #1; end
        exp_q.delete();
        #1 rst = 1'b1;
        #1 check_reset_outputs("midrst");
        repeat (3) begin
            @(negedge clk);
            check("midrst_no_done", done, 1'b0);
        end
        #2 rst = 1'b0;
        run_full(p, fa, cnt);
        check("after_rst_pass", pass, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_march_bist.md
SRAM_MARCH_BIST -- requirements
Module: sram_march_bist

Interface
REQ-001 DATA_WIDTH, 32, SRAM word width in bits.
REQ-002 ADDR_WIDTH, 8, SRAM address width; depth = 2^ADDR_WIDTH.
REQ-003 NUM_WMASKS, 4, number of write-mask bits.
REQ-004 PATTERN, 32'h5555_5555, background data word; its inverse is ~PATTERN.
REQ-005 clk  in  1  single clock for all logic; also the SRAM port-0 clock.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  single-cycle request to begin a test.
REQ-008 abort  in  1  stops a running test.
REQ-009 busy  out  1  high while a test runs.
REQ-010 done  out  1  high after a test completes; held until the next accepted start.
REQ-011 pass  out  1  valid while done=1; 1 means no mismatch was found.
REQ-012 fail_addr  out  ADDR_WIDTH  address of the first mismatch.
REQ-013 csb0  out  1  SRAM port-0 chip select, active-low.
REQ-014 web0  out  1  SRAM port-0 write enable, active-low.
REQ-015 wmask0  out  NUM_WMASKS  write mask; all ones on every write.
REQ-016 addr0  out  ADDR_WIDTH  SRAM port-0 address.
REQ-017 din0  out  DATA_WIDTH  SRAM port-0 write data.
REQ-018 dout0  in  DATA_WIDTH  SRAM port-0 read data, valid one cycle after the read cycle.

Function
REQ-019 The state machine SHALL have the states IDLE, W0, R0W1, R1, FLUSH and DONE.
REQ-020 In IDLE or DONE, start=1 SHALL enter W0 on the next cycle with the address at 0 and SHALL clear pass, fail_addr and the error state.
REQ-021 start while busy=1 SHALL be ignored.
REQ-022 W0 SHALL issue one write per cycle (csb0=0, web0=0, din0=PATTERN) for addresses 0 up to 2^ADDR_WIDTH-1, then enter R0W1 at address 0.
REQ-023 R0W1 SHALL use two cycles per address: a read (csb0=0, web0=1), then a write of ~PATTERN to the same address, in ascending order.
REQ-024 In R0W1, dout0 SHALL be sampled in the write cycle and compared to PATTERN.
REQ-025 After the last address, R0W1 SHALL enter R1 at address 2^ADDR_WIDTH-1.
REQ-026 R1 SHALL issue one read per cycle, descending to address 0.
REQ-027 Each R1 read SHALL be compared one cycle later against ~PATTERN; the comparison SHALL use the address of the originating read.
REQ-028 After the read of address 0, R1 SHALL enter FLUSH for one cycle (csb0=1) to compare the last read, then enter DONE.
REQ-029 busy SHALL be high from the cycle after start is accepted through FLUSH: exactly 4*2^ADDR_WIDTH+1 cycles (1025 at the defaults).
REQ-030 On the first mismatch, fail_addr SHALL capture the mismatching address and pass SHALL become 0 at DONE; later mismatches SHALL NOT change fail_addr.
REQ-031 abort=1 in any busy state SHALL return the block to IDLE on the next cycle with csb0=1, done=0 and pass=0.
REQ-032 abort SHALL take priority over start and over all state transitions in the same cycle.
REQ-033 csb0 SHALL be 1 in IDLE, FLUSH and DONE; the address counter SHALL wrap only by explicit state change, never by overflow.

Reset
REQ-034 While rst=1, the block SHALL asynchronously force: state=IDLE, busy=0, done=0, pass=0, fail_addr=0, csb0=1, web0=1, wmask0=all ones, addr0=0, din0=0.
REQ-035 Reset mid-test SHALL abandon the test without asserting done.

Configuration
REQ-036 With ERR_COUNT_EN defined, the block SHALL have the output err_count (16 bits): a count of all mismatches, cleared on accepted start, saturating at 16'hFFFF, and held in DONE.
REQ-037 Without ERR_COUNT_EN, the err_count port and counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-038 ADDR_WIDTH=4 with an ideal SRAM model, start pulse -> busy high for 65 cycles; then done=1, pass=1, fail_addr=0.
REQ-039 Stuck-at-1 on bit 0 of address 0x3 -> R1 mismatch (reads AAAA_AAAB); done with pass=0, fail_addr=0x3, err_count=1.
REQ-040 Data stuck at 0 on addresses 0x5 and 0x9 -> fail_addr=0x5 (first found in R0W1); err_count=4.
REQ-041 abort at W0 address 0x7 -> next cycle: IDLE, csb0=1, busy=0, done=0; a following start runs a full pass=1 test.
REQ-042 start held high throughout a test -> no restart until DONE; in DONE it restarts, and done drops on the next cycle.
REQ-043 rst asserted during R0W1 -> outputs immediately take the reset values of REQ-034, with no done pulse.
